// File: rtl/fifo_16x8.sv
// fifo_16x8
//   Single-clock byte FIFO, 16 entries deep. It decouples a byte producer
//   from a byte consumer running in the same clock domain. Read data is
//   registered, so a popped byte appears on rdata_out after the clock edge
//   that accepts the read.
//
// Ports
//   clock_in    : system clock, all state updates on the rising edge
//   n_reset_in  : asynchronous active-low reset
//   write_in    : push request, sampled on the rising edge
//   wdata_in    : byte stored when a push is accepted
//   read_in     : pop request, sampled on the rising edge
//   rdata_out   : byte from the most recently accepted pop (held otherwise)
//   empty_out   : high while the FIFO holds no entries
//   full_out    : high while the FIFO holds 2**ADDR_WIDTH entries
module fifo_16x8 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock_in,
  input  logic                  n_reset_in,
  input  logic                  write_in,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  input  logic                  read_in,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic                  empty_out,
  output logic                  full_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] COUNT_FULL = ADDR_WIDTH'(0) + (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic wr_accept;
  logic rd_accept;

  // Flags come straight from the registered count, so they only move after
  // a clock edge or a reset.
  assign empty_out = (count_q == '0);
  assign full_out  = (count_q == COUNT_FULL);
  assign rdata_out = rdata_q;

  // A write into a full FIFO still goes through when a read frees a slot on
  // the same edge. A read is never accepted while empty, so a simultaneous
  // read+write on an empty FIFO is just a write.
  assign wr_accept = write_in & (~full_out | read_in);
  assign rd_accept = read_in & ~empty_out;

  // Next-state for pointers, count and registered read data. Pointers wrap
  // naturally at the top of the address range.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    rdata_d = rdata_q;

    if (wr_accept) begin
      wptr_d = wptr_q + 1'b1;
    end

    if (rd_accept) begin
      rptr_d  = rptr_q + 1'b1;
      rdata_d = mem_q[rptr_q];
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset empties the FIFO without touching storage.
  always_ff @(posedge clock_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage has no reset; only accepted writes touch it, so data presented
  // during a rejected write is never sampled.
  always_ff @(posedge clock_in) begin
    if (wr_accept) begin
      mem_q[wptr_q] <= wdata_in;
    end
  end

endmodule

// File: tb/tb_fifo_16x8.sv
// tb_fifo_16x8
//   Self-checking bench for fifo_16x8. A queue models the FIFO contents:
//   accepted writes push the driven byte, accepted reads pop the expected
//   rdata_out value, and each scenario task compares the DUT outputs against
//   the model one time unit after the active edge.
module tb_fifo_16x8;

  logic       clock_in;
  logic       n_reset_in;
  logic       write_in;
  logic [7:0] wdata_in;
  logic       read_in;
  logic [7:0] rdata_out;
  logic       empty_out;
  logic       full_out;

  logic [7:0] sb[$];
  logic [7:0] exp_rdata;
  int         total;
  int         bad;

  fifo_16x8 dut (
    .clock_in  (clock_in),
    .n_reset_in(n_reset_in),
    .write_in  (write_in),
    .wdata_in  (wdata_in),
    .read_in   (read_in),
    .rdata_out (rdata_out),
    .empty_out (empty_out),
    .full_out  (full_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Drives one cycle of stimulus and updates the model on the edge: an
  // accepted read pops the expected output byte, an accepted write pushes
  // the driven byte. Pop happens before push so a full read+write keeps 16.
  task automatic drive(input logic w, input logic [7:0] d, input logic r);
    bit rd_ok;
    bit wr_ok;
    @(negedge clock_in);
    write_in = w;
    wdata_in = d;
    read_in  = r;
    rd_ok = r && (sb.size() > 0);
    wr_ok = w && ((sb.size() < 16) || r);
    @(posedge clock_in);
    if (rd_ok) exp_rdata = sb.pop_front();
    if (wr_ok) sb.push_back(d);
    #1;
    write_in = 1'b0;
    read_in  = 1'b0;
    wdata_in = 8'h00;
  endtask

  task automatic test_reset();
    n_reset_in = 1'b0;
    write_in   = 1'b0;
    read_in    = 1'b0;
    wdata_in   = 8'h00;
    sb.delete();
    exp_rdata  = 8'h00;
    #12;
    n_reset_in = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    total += 3;
    if (empty_out !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty: got %b want 1", empty_out); end
    if (full_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_full: got %b want 0", full_out); end
    if (rdata_out !== 8'h00) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 00", rdata_out); end
  endtask

  task automatic test_single();
    drive(1'b1, 8'hAA, 1'b0);
    total++;
    if (empty_out !== 1'b0) begin bad++; $display("[TB] FAIL single_empty_after_write: got %b want 0", empty_out); end
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    total += 3;
    if (rdata_out !== exp_rdata || rdata_out !== 8'hAA) begin bad++; $display("[TB] FAIL single_rdata: got %h want %h", rdata_out, exp_rdata); end
    if (empty_out !== 1'b1) begin bad++; $display("[TB] FAIL single_empty_after_read: got %b want 1", empty_out); end
    if (full_out !== 1'b0) begin bad++; $display("[TB] FAIL single_full: got %b want 0", full_out); end
  endtask

  task automatic test_read_empty();
    drive(1'b0, 8'h00, 1'b1);
    total += 3;
    if (rdata_out !== 8'hAA) begin bad++; $display("[TB] FAIL rd_empty_rdata: got %h want AA", rdata_out); end
    if (empty_out !== 1'b1) begin bad++; $display("[TB] FAIL rd_empty_empty: got %b want 1", empty_out); end
    if (full_out !== 1'b0) begin bad++; $display("[TB] FAIL rd_empty_full: got %b want 0", full_out); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      total += 2;
      if (empty_out !== 1'b0) begin bad++; $display("[TB] FAIL fill_empty[%0d]: got %b want 0", i, empty_out); end
      if (full_out !== (i == 15)) begin bad++; $display("[TB] FAIL fill_full[%0d]: got %b want %b", i, full_out, (i == 15)); end
    end
    drive(1'b1, 8'hxx, 1'b0);
    total += 2;
    if (full_out !== 1'b1) begin bad++; $display("[TB] FAIL overflow_full: got %b want 1", full_out); end
    if (rdata_out !== 8'hAA) begin bad++; $display("[TB] FAIL overflow_rdata: got %h want AA", rdata_out); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(8'h10 + i), 1'b1);
      total += 3;
      if (rdata_out !== exp_rdata || rdata_out !== 8'(i)) begin bad++; $display("[TB] FAIL b2b_rdata[%0d]: got %h want %h", i, rdata_out, exp_rdata); end
      if (full_out !== 1'b1) begin bad++; $display("[TB] FAIL b2b_full[%0d]: got %b want 1", i, full_out); end
      if (empty_out !== 1'b0) begin bad++; $display("[TB] FAIL b2b_empty[%0d]: got %b want 0", i, empty_out); end
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      total += 3;
      if (rdata_out !== exp_rdata || rdata_out !== 8'(8'h10 + i)) begin bad++; $display("[TB] FAIL drain_rdata[%0d]: got %h want %h", i, rdata_out, exp_rdata); end
      if (full_out !== 1'b0) begin bad++; $display("[TB] FAIL drain_full[%0d]: got %b want 0", i, full_out); end
      if (empty_out !== (i == 15)) begin bad++; $display("[TB] FAIL drain_empty[%0d]: got %b want %b", i, empty_out, (i == 15)); end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      total += 2;
      if (rdata_out !== 8'h1F) begin bad++; $display("[TB] FAIL drain_extra_rdata[%0d]: got %h want 1F", i, rdata_out); end
      if (empty_out !== 1'b1) begin bad++; $display("[TB] FAIL drain_extra_empty[%0d]: got %b want 1", i, empty_out); end
    end
  endtask

  task automatic test_empty_rw();
    // read+write on an empty FIFO: only the write lands
    drive(1'b1, 8'h5C, 1'b1);
    total += 2;
    if (empty_out !== 1'b0) begin bad++; $display("[TB] FAIL empty_rw_empty: got %b want 0", empty_out); end
    if (rdata_out !== 8'h1F) begin bad++; $display("[TB] FAIL empty_rw_rdata: got %h want 1F", rdata_out); end
    drive(1'b0, 8'h00, 1'b1);
    total += 2;
    if (rdata_out !== exp_rdata || rdata_out !== 8'h5C) begin bad++; $display("[TB] FAIL empty_rw_pop: got %h want %h", rdata_out, exp_rdata); end
    if (empty_out !== 1'b1) begin bad++; $display("[TB] FAIL empty_rw_empty2: got %b want 1", empty_out); end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 8'h31, 1'b0);
    drive(1'b1, 8'h32, 1'b0);
    drive(1'b1, 8'h33, 1'b0);
    total++;
    if (empty_out !== 1'b0) begin bad++; $display("[TB] FAIL midrst_pre_empty: got %b want 0", empty_out); end
    #2;
    n_reset_in = 1'b0;
    sb.delete();
    exp_rdata = 8'h00;
    #1;
    total += 3;
    if (empty_out !== 1'b1) begin bad++; $display("[TB] FAIL midrst_empty: got %b want 1", empty_out); end
    if (full_out !== 1'b0) begin bad++; $display("[TB] FAIL midrst_full: got %b want 0", full_out); end
    if (rdata_out !== 8'h00) begin bad++; $display("[TB] FAIL midrst_rdata: got %h want 00", rdata_out); end
    #2;
    n_reset_in = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    total += 2;
    if (rdata_out !== 8'h00) begin bad++; $display("[TB] FAIL midrst_read_rdata: got %h want 00", rdata_out); end
    if (empty_out !== 1'b1) begin bad++; $display("[TB] FAIL midrst_read_empty: got %b want 1", empty_out); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_read_empty();
    test_fill();
    test_back_to_back();
    test_drain();
    test_empty_rw();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
